fifo_wptr_full: RTL and testbench

- Write-domain pointer and flag stage of the asynchronous FIFO; sits directly upstream of the dual-port memory.
- Produces the memory write address and the registered full flag that gate memory writes.
- Exports the Gray-coded write pointer to the read domain.
- Imports the read domain's Gray pointer through a 2-flop synchronizer and derives full, almost_full and the write-side fill level.

---
 rtl/fifo_pkg.sv | 35 +++
 rtl/sync_2ff.sv | 29 ++
 rtl/fifo_wptr_full.sv | 102 ++++++++++
 tb/tb_fifo_wptr_full.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the asynchronous FIFO pointer blocks (write and read side).
package fifo_pkg;

   localparam int SYNC_STAGES = 2;
   localparam int PTR_MAX     = 32;

   function automatic logic [PTR_MAX-1:0] width_mask(input int unsigned width);
      logic [PTR_MAX-1:0] mask;
      if (width >= PTR_MAX)
         mask = '1;
      else
         mask = (PTR_MAX'(1) << width) - PTR_MAX'(1);
      return mask;
   endfunction

   function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b,
                                                   input int unsigned width);
      logic [PTR_MAX-1:0] bm;
      bm = b & width_mask(width);
      return bm ^ (bm >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at and above it.
   function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g,
                                                   input int unsigned width);
      logic [PTR_MAX-1:0] gm;
      logic [PTR_MAX-1:0] b;
      gm = g & width_mask(width);
      b  = '0;
      for (int i = 0; i < PTR_MAX; i++)
         b[i] = ^(gm >> i);
      return b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Multi-flop synchronizer for Gray-coded pointers crossing clock domains.
module sync_2ff
   import fifo_pkg::*;
#(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : g_bit
         logic [SYNC_STAGES-1:0] sh_reg;

         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               sh_reg <= '0;
            else
               sh_reg <= {sh_reg[SYNC_STAGES-2:0], d[gi]};
         end

         assign q[gi] = sh_reg[SYNC_STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer, full/almost_full and fill level of the async FIFO.
// Define FIFO_WPTR_OVERFLOW_EN to add the sticky overflow output.
module fifo_wptr_full
   import fifo_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int ADDR  = $clog2(DEPTH),
   parameter int AF_TH = DEPTH - 2
) (
   input  logic            wclk,
   input  logic            wrst,
   input  logic            wr,
   input  logic [ADDR:0]   rptr_gray,
   output logic [ADDR-1:0] Waddr,
   output logic [ADDR:0]   wptr_gray,
   output logic            full,
   output logic            almost_full,
   output logic [ADDR:0]   wlevel
`ifdef FIFO_WPTR_OVERFLOW_EN
   ,
   output logic            overflow
`endif
);

   localparam int            PW     = ADDR + 1;
   localparam logic [ADDR:0] AF_LIM = PW'(AF_TH);

   logic [ADDR:0] wbin_reg;
   logic [ADDR:0] wbin_next;
   logic [ADDR:0] wgray_reg;
   logic [ADDR:0] wgray_next;
   logic [ADDR:0] wlevel_reg;
   logic [ADDR:0] level_next;
   logic [ADDR:0] rq2;
   logic [ADDR:0] rbin_s;
   logic [ADDR:0] full_cmp;
   logic          full_reg;
   logic          full_next;
   logic          af_reg;
   logic          af_next;
   logic          wen;

   sync_2ff #(
      .W (PW)
   ) u_rptr_sync (
      .clk (wclk),
      .rst (wrst),
      .d   (rptr_gray),
      .q   (rq2)
   );

   assign rbin_s = PW'(gray2bin(PTR_MAX'(rq2), PW));

   // Full when the write pointer is one lap ahead: top two Gray bits inverted.
   assign full_cmp = {~rq2[ADDR:ADDR-1], rq2[ADDR-2:0]};

   always_comb begin
      wen        = wr & ~full_reg;
      wbin_next  = wbin_reg + {{ADDR{1'b0}}, wen};
      wgray_next = PW'(bin2gray(PTR_MAX'(wbin_next), PW));
      level_next = wbin_next - rbin_s;
      full_next  = (wgray_next == full_cmp);
      af_next    = (level_next >= AF_LIM);
   end

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         wbin_reg   <= '0;
         wgray_reg  <= '0;
         full_reg   <= 1'b0;
         af_reg     <= 1'b0;
         wlevel_reg <= '0;
      end else begin
         wbin_reg   <= wbin_next;
         wgray_reg  <= wgray_next;
         full_reg   <= full_next;
         af_reg     <= af_next;
         wlevel_reg <= level_next;
      end
   end

   assign Waddr       = wbin_reg[ADDR-1:0];
   assign wptr_gray   = wgray_reg;
   assign full        = full_reg;
   assign almost_full = af_reg;
   assign wlevel      = wlevel_reg;

`ifdef FIFO_WPTR_OVERFLOW_EN
   logic ovf_reg;

   // Sticky: any attempted write against a full FIFO is remembered until reset.
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst)
         ovf_reg <= 1'b0;
      else if (wr && full_reg)
         ovf_reg <= 1'b1;
   end

   assign overflow = ovf_reg;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full against a count-based FIFO model.
module tb_fifo_wptr_full;

   localparam int DEPTH = 8;
   localparam int ADDR  = 3;
   localparam int AF_TH = 6;

   logic            wclk = 1'b0;
   logic            wrst;
   logic            wr;
   logic [ADDR:0]   rptr_gray;
   logic [ADDR-1:0] Waddr;
   logic [ADDR:0]   wptr_gray;
   logic            full;
   logic            almost_full;
   logic [ADDR:0]   wlevel;
`ifdef FIFO_WPTR_OVERFLOW_EN
   logic            overflow;
`endif

   always #5 wclk = ~wclk;

   fifo_wptr_full #(
      .DEPTH (DEPTH),
      .ADDR  (ADDR),
      .AF_TH (AF_TH)
   ) dut (
      .wclk        (wclk),
      .wrst        (wrst),
      .wr          (wr),
      .rptr_gray   (rptr_gray),
      .Waddr       (Waddr),
      .wptr_gray   (wptr_gray),
      .full        (full),
      .almost_full (almost_full),
      .wlevel      (wlevel)
`ifdef FIFO_WPTR_OVERFLOW_EN
      ,
      .overflow    (overflow)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model: total writes accepted, total reads issued, and the read count as
   // seen by the write side two edges later.
   int            wcount;
   int            rcnt;
   int            s1;
   int            s2;
   int            m_level;
   bit            m_full;
   bit            m_af;
   bit            m_ovf;
   logic [ADDR:0] prev_gray;

   function automatic logic [ADDR:0] to_gray(input int n);
      logic [ADDR:0] b;
      b = n[ADDR:0];
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_outputs();
      chk("Waddr", int'(Waddr), wcount % DEPTH);
      chk("wptr_gray", int'(wptr_gray), int'(to_gray(wcount)));
      chk("full", int'(full), int'(m_full));
      chk("almost_full", int'(almost_full), int'(m_af));
      chk("wlevel", int'(wlevel), m_level);
`ifdef FIFO_WPTR_OVERFLOW_EN
      chk("overflow", int'(overflow), int'(m_ovf));
`endif
      chk("gray_step", int'($countones(prev_gray ^ wptr_gray) <= 1), 1);
      prev_gray = wptr_gray;
   endtask

   task automatic model_reset();
      wcount    = 0;
      rcnt      = 0;
      s1        = 0;
      s2        = 0;
      m_level   = 0;
      m_full    = 1'b0;
      m_af      = 1'b0;
      m_ovf     = 1'b0;
      prev_gray = '0;
   endtask

   // One write-clock transaction; called right after a falling edge.
   task automatic cycle(input bit w, input bit rinc);
      wr = w;
      if (rinc && rcnt < wcount)
         rcnt++;
      rptr_gray = to_gray(rcnt);
      @(posedge wclk);
      if (w && m_full)
         m_ovf = 1'b1;
      if (w && !m_full)
         wcount++;
      m_level = wcount - s2;
      s2      = s1;
      s1      = rcnt;
      m_full  = (m_level == DEPTH);
      m_af    = (m_level >= AF_TH);
      @(negedge wclk);
      $display("[TB] wr=%0b rptr_gray=%b Waddr=%0d wptr_gray=%b full=%0b af=%0b wlevel=%0d",
               w, rptr_gray, Waddr, wptr_gray, full, almost_full, wlevel);
      check_outputs();
   endtask

   // Asynchronous reset between edges; outputs must clear before any clock.
   task automatic async_reset();
      #2;
      wrst = 1'b1;
      #1;
      chk("rst_Waddr", int'(Waddr), 0);
      chk("rst_wptr_gray", int'(wptr_gray), 0);
      chk("rst_full", int'(full), 0);
      chk("rst_wlevel", int'(wlevel), 0);
      chk("rst_almost_full", int'(almost_full), 0);
      model_reset();
      wr        = 1'b0;
      rptr_gray = '0;
      @(posedge wclk);
      @(negedge wclk);
      wrst = 1'b0;
      check_outputs();
   endtask

   initial begin
      wrst      = 1'b1;
      wr        = 1'b0;
      rptr_gray = '0;
      model_reset();
      @(negedge wclk);
      @(negedge wclk);
      wrst = 1'b0;
      check_outputs();

      // Fill from empty with the reader idle.
      for (int i = 0; i < DEPTH; i++)
         cycle(1'b1, 1'b0);
      chk("fill_wlevel", int'(wlevel), DEPTH);
      chk("fill_full", int'(full), 1);
      chk("fill_gray", int'(wptr_gray), 12);

      // Writes against a full FIFO are dropped.
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 1'b0);
      chk("ovf_Waddr", int'(Waddr), 0);

      // One read: full must hold for two edges and drop on the third.
      cycle(1'b0, 1'b1);
      chk("drain_e1_full", int'(full), 1);
      cycle(1'b0, 1'b0);
      chk("drain_e2_full", int'(full), 1);
      cycle(1'b0, 1'b0);
      chk("drain_e3_full", int'(full), 0);
      chk("drain_e3_wlevel", int'(wlevel), DEPTH - 1);

      // Write lands on the same edge the synchronized read pointer advances.
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b0);
      chk("simul_wlevel", int'(wlevel), DEPTH - 1);
      chk("simul_full", int'(full), 0);

      // Reset in the middle of a burst.
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b0);
      wr = 1'b1;
      async_reset();
      cycle(1'b1, 1'b0);
      chk("post_rst_first_addr", int'(Waddr), 1);

      // Wrap the binary pointer with the reader trailing close behind.
      for (int i = 0; i < 19; i++)
         cycle(1'b1, (rcnt + 2) < wcount);
      chk("wrap_wptr_gray", int'(wptr_gray), int'(to_gray(20)));

      // Randomized traffic, alternating write-heavy and read-heavy phases.
      for (int p = 0; p < 6; p++) begin
         for (int i = 0; i < 60; i++) begin
            if (p % 2 == 0)
               cycle(($urandom % 4) != 0, ($urandom % 4) == 0);
            else
               cycle(($urandom % 4) == 0, ($urandom % 4) != 0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
